rv32i_branch_predictor: RTL and testbench
=========================================

# rv32i_branch_predictor

Dynamic branch predictor for the rv32i pipeline that replaces fixed predict-not-taken. Sits beside the PC register and IF/ID register: an IF-stage lookup supplies next-PC prediction, an ID-stage resolve port trains the tables and flags mispredictions. Branch-target buffer with per-entry saturating counters, parametrised in depth, tag width and counter width. Misprediction detection and redirect PC generation are included.

## Interface
Parameters:
- DataWidth, 32, PC/target width
- Entries, 64, BTB entries; power of two, ≥2
- TagWidth, 8, stored PC tag bits
- CtrWidth, 2, saturating counter width, ≥1

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low
- if_pc  input  DataWidth  PC of instruction being fetched
- pred_taken  output  1  IF-stage prediction: redirect fetch
- pred_target  output  DataWidth  predicted next PC when pred_taken
- stall  input  1  hold ID-stage prediction register (same stall as IF/ID)
- res_valid  input  1  branch resolved in ID this cycle
- res_pc  input  DataWidth  PC of resolved branch
- res_taken  input  1  actual outcome
- res_target  input  DataWidth  actual target (pc + offset)
- mispredict  output  1  ID-stage prediction wrong; flush IF/ID
- redirect_pc  output  DataWidth  correct next PC when mispredict
- stat_branches  output  32  resolved-branch count (macro-gated)
- stat_mispredicts  output  32  misprediction count (macro-gated)

## Operation
- Index = pc[IdxW+1:2], IdxW = log2(Entries); tag = pc[IdxW+2+TagWidth-1:IdxW+2].
- Entry: valid, tag, target, counter.
- Lookup (combinational): hit = valid && tag match; pred_taken = hit && counter MSB; pred_target = entry target when hit, else if_pc+4.
- ID prediction register: captures {pred_taken, pred_target} each non-stalled edge, aligned with IF/ID. Loaded with {0, 0} when mispredict is high (flushed slot is a NOP).
- mispredict = res_valid && (res_taken != id_pred_taken || (res_taken && res_target != id_pred_target)).
- redirect_pc = res_taken ? res_target : res_pc+4 (mod 2^DataWidth).
- Training, on res_valid edge, regardless of stall:
  - Hit: counter ±1, saturating at 0 and 2^CtrWidth−1; target overwritten with res_target when taken.
  - Miss, taken: allocate; valid=1, tag, target, counter=weak-taken (1<<(CtrWidth−1)).
  - Miss, not taken: no change.
- Lookup and update at the same index in one cycle: lookup returns pre-update contents.

## Timing
- Lookup and mispredict/redirect_pc: zero-cycle combinational.
- Training is visible to lookups on the cycle after the res_valid edge.
- Reset (asynchronous, any time, including mid-update): all valid bits cleared, counters to weak-not-taken ((1<<(CtrWidth−1))−1; 0 when CtrWidth=1), ID prediction register {0, 0}, stats 0.
- Outputs during reset: pred_taken=0, pred_target=if_pc+4, mispredict=0 (res_valid ignored).
- stall high: ID prediction register holds. Tables still train.

## Configuration
- RV32I_BP_STATS_EN defined: two 32-bit counters increment on res_valid and on mispredict respectively, saturating at 0xFFFFFFFF.
- RV32I_BP_STATS_EN undefined: counter logic absent; stat_branches and stat_mispredicts tied to 0.

## Structure
- Shared package `definitions`:
  - bp_entry_t struct (valid, tag, target, counter), parametrised via localparams
  - counter constants: weak-taken, weak-not-taken
- Sub-module bp_sat_counter: CtrWidth up/down saturating update, pure function of {current, taken}. Instantiated once, on the update path.
- Top holds the table array, ID prediction register and stats.

## Test plan
- After reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104; stats 0.
- res_valid, res_pc=0x100, taken, target=0x80 -> next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x80; counter=2.
- Three not-taken resolves at 0x100 -> counter 2→1→0→0 (saturates); pred_taken=0 after the first.
- Predicted taken to 0x80, resolved not taken -> mispredict=1, redirect_pc=0x104, ID prediction register flushed to {0, 0}; stat_mispredicts=1.
- Aliasing: 0x100 trained, lookup at 0x100+4·Entries (different tag) -> pred_taken=0; taken resolve there replaces the entry; 0x100 now misses.
- Reset asserted mid-cycle with res_valid=1 -> all lookups miss, no allocation occurs, stats return to 0.

Source files
------------

// File: rtl/rv32i_branch_predictor_pkg.sv
// Shared branch-predictor definitions: default-width entry layout and
// saturating-counter reset/allocation constants.
package definitions;

  localparam int BpDataW = 32;
  localparam int BpTagW  = 8;
  localparam int BpCtrW  = 2;

  typedef struct packed {
    logic               valid;
    logic [BpTagW-1:0]  tag;
    logic [BpDataW-1:0] target;
    logic [BpCtrW-1:0]  counter;
  } bp_entry_t;

  // Weak-taken is the lowest value with the MSB set; weak-not-taken sits just below it.
  function automatic int unsigned ctr_weak_taken(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned ctr_weak_not_taken(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  localparam logic [BpCtrW-1:0] CtrWeakTaken    = BpCtrW'(ctr_weak_taken(BpCtrW));
  localparam logic [BpCtrW-1:0] CtrWeakNotTaken = BpCtrW'(ctr_weak_not_taken(BpCtrW));

endpackage

// File: rtl/rv32i_branch_predictor_sat_counter.sv
// Up/down saturating counter update: next value from {current, taken}.
module bp_sat_counter #(
  parameter int CtrWidth = 2
) (
  input  logic [CtrWidth-1:0] i_ctr,
  input  logic                i_taken,
  output logic [CtrWidth-1:0] o_ctr
);

  localparam logic [CtrWidth-1:0] CtrMax = '1;

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != CtrMax) o_ctr = i_ctr + CtrWidth'(1);
    end else begin
      if (i_ctr != '0) o_ctr = i_ctr - CtrWidth'(1);
    end
  end

endmodule

// File: rtl/rv32i_branch_predictor.sv
// BTB-based dynamic branch predictor: IF-stage lookup, ID-stage resolve/train,
// mispredict + redirect. Optional statistics counters under RV32I_BP_STATS_EN.
module rv32i_branch_predictor
  import definitions::*;
#(
  parameter int DataWidth = 32,
  parameter int Entries   = 64,
  parameter int TagWidth  = 8,
  parameter int CtrWidth  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] if_pc,
  output logic                 pred_taken,
  output logic [DataWidth-1:0] pred_target,
  input  logic                 stall,
  input  logic                 res_valid,
  input  logic [DataWidth-1:0] res_pc,
  input  logic                 res_taken,
  input  logic [DataWidth-1:0] res_target,
  output logic                 mispredict,
  output logic [DataWidth-1:0] redirect_pc,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  localparam int IdxW = $clog2(Entries);
  localparam int TagLo = IdxW + 2;
  localparam logic [CtrWidth-1:0] CtrWeakT  = CtrWidth'(ctr_weak_taken(CtrWidth));
  localparam logic [CtrWidth-1:0] CtrWeakNT = CtrWidth'(ctr_weak_not_taken(CtrWidth));

  function automatic logic [DataWidth-1:0] next_seq_pc(input logic [DataWidth-1:0] pc);
    return pc + DataWidth'(4);
  endfunction

  logic                 r_valid  [Entries];
  logic [CtrWidth-1:0]  r_ctr    [Entries];
  logic [TagWidth-1:0]  r_tag    [Entries];
  logic [DataWidth-1:0] r_target [Entries];

  logic                 r_pred_taken_p1;
  logic [DataWidth-1:0] r_pred_target_p1;

  logic [IdxW-1:0]      w_if_idx_p0;
  logic [TagWidth-1:0]  w_if_tag_p0;
  logic                 w_if_hit_p0;
  logic [IdxW-1:0]      w_res_idx_p1;
  logic [TagWidth-1:0]  w_res_tag_p1;
  logic                 w_res_hit_p1;
  logic [CtrWidth-1:0]  w_ctr_next_p1;
  logic                 w_mispredict_p1;

  // ---- IF stage: combinational lookup (reads pre-update table contents)
  assign w_if_idx_p0 = if_pc[IdxW+1:2];
  assign w_if_tag_p0 = if_pc[TagLo+TagWidth-1:TagLo];
  assign w_if_hit_p0 = rst && r_valid[w_if_idx_p0] && (r_tag[w_if_idx_p0] == w_if_tag_p0);

  assign pred_taken  = w_if_hit_p0 && r_ctr[w_if_idx_p0][CtrWidth-1];
  assign pred_target = w_if_hit_p0 ? r_target[w_if_idx_p0] : next_seq_pc(if_pc);

  // ---- ID stage: prediction register aligned with IF/ID; a flushed slot is a NOP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pred_taken_p1  <= 1'b0;
      r_pred_target_p1 <= '0;
    end else if (w_mispredict_p1) begin
      r_pred_taken_p1  <= 1'b0;
      r_pred_target_p1 <= '0;
    end else if (!stall) begin
      r_pred_taken_p1  <= pred_taken;
      r_pred_target_p1 <= pred_target;
    end
  end

  assign w_mispredict_p1 = rst && res_valid &&
                           ((res_taken != r_pred_taken_p1) ||
                            (res_taken && (res_target != r_pred_target_p1)));
  assign mispredict  = w_mispredict_p1;
  assign redirect_pc = res_taken ? res_target : next_seq_pc(res_pc);

  assign w_res_idx_p1 = res_pc[IdxW+1:2];
  assign w_res_tag_p1 = res_pc[TagLo+TagWidth-1:TagLo];
  assign w_res_hit_p1 = r_valid[w_res_idx_p1] && (r_tag[w_res_idx_p1] == w_res_tag_p1);

  bp_sat_counter #(
    .CtrWidth (CtrWidth)
  ) u_sat_counter (
    .i_ctr   (r_ctr[w_res_idx_p1]),
    .i_taken (res_taken),
    .o_ctr   (w_ctr_next_p1)
  );

  // Training ignores stall; a not-taken miss leaves the table untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CtrWeakNT;
      end
    end else if (res_valid) begin
      if (w_res_hit_p1) begin
        r_ctr[w_res_idx_p1] <= w_ctr_next_p1;
      end else if (res_taken) begin
        r_valid[w_res_idx_p1] <= 1'b1;
        r_ctr[w_res_idx_p1]   <= CtrWeakT;
      end
    end
  end

  // Tag rewrite on a taken hit is a no-op, so allocation and target refresh share one write.
  always_ff @(posedge clk) begin
    if (res_valid && res_taken) begin
      r_tag[w_res_idx_p1]    <= w_res_tag_p1;
      r_target[w_res_idx_p1] <= res_target;
    end
  end

`ifdef RV32I_BP_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (res_valid)       r_stat_branches    <= sat_inc32(r_stat_branches);
      if (w_mispredict_p1) r_stat_mispredicts <= sat_inc32(r_stat_mispredicts);
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_rv32i_branch_predictor.sv
// Self-checking bench for rv32i_branch_predictor: directed vector table,
// reset corner sequences, and randomized traffic against a behavioural model.
module tb_rv32i_branch_predictor;

  localparam int DW    = 32;
  localparam int ENT   = 64;
  localparam int TAGW  = 8;
  localparam int CTRW  = 2;
  localparam int IDXW  = $clog2(ENT);
  localparam int CTRMX = (1 << CTRW) - 1;
`ifdef RV32I_BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] if_pc;
  logic          pred_taken;
  logic [DW-1:0] pred_target;
  logic          stall;
  logic          res_valid;
  logic [DW-1:0] res_pc;
  logic          res_taken;
  logic [DW-1:0] res_target;
  logic          mispredict;
  logic [DW-1:0] redirect_pc;
  logic [31:0]   stat_branches;
  logic [31:0]   stat_mispredicts;

  always #5 clk = ~clk;

  rv32i_branch_predictor #(
    .DataWidth (DW),
    .Entries   (ENT),
    .TagWidth  (TAGW),
    .CtrWidth  (CTRW)
  ) dut (
    .clk              (clk),
    .rst              (rst_n),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .stall            (stall),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid  [ENT];
  int          m_tag    [ENT];
  logic [31:0] m_target [ENT];
  int          m_ctr    [ENT];
  logic        m_id_taken;
  logic [31:0] m_id_target;
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic int m_idx(input logic [31:0] pc);
    return int'(pc[31:2]) % ENT;
  endfunction

  function automatic int m_tagof(input logic [31:0] pc);
    return int'(pc >> (2 + IDXW)) % (1 << TAGW);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = (1 << (CTRW - 1)) - 1;
    end
    m_id_taken  = 1'b0;
    m_id_target = '0;
    m_br        = '0;
    m_mp        = '0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int idx;
    bit hit;
    idx = m_idx(pc);
    hit = m_valid[idx] && (m_tag[idx] == m_tagof(pc));
    t   = hit && (m_ctr[idx] >= (1 << (CTRW - 1)));
    tg  = hit ? m_target[idx] : pc + 32'd4;
  endfunction

  function automatic void m_train(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    int idx;
    idx = m_idx(pc);
    if (m_valid[idx] && (m_tag[idx] == m_tagof(pc))) begin
      if (tk) begin
        m_ctr[idx]    = (m_ctr[idx] < CTRMX) ? m_ctr[idx] + 1 : CTRMX;
        m_target[idx] = tg;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = m_tagof(pc);
      m_target[idx] = tg;
      m_ctr[idx]    = 1 << (CTRW - 1);
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtg;
    logic        st;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mp;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    logic        ept;
    logic [31:0] eptg;
    logic        emp;
    logic [31:0] erd;
    logic [31:0] pcs;

    //            pc        rv  rpc       rt  rtg       st  pt  ptg       mp  redirect
    vecs[0]  = '{32'h100, 0, 32'h000, 0, 32'h000, 0, 0, 32'h104, 0, 32'h004};
    vecs[1]  = '{32'h200, 1, 32'h100, 1, 32'h080, 0, 0, 32'h204, 1, 32'h080};
    vecs[2]  = '{32'h100, 0, 32'h000, 0, 32'h000, 0, 1, 32'h080, 0, 32'h004};
    vecs[3]  = '{32'h104, 1, 32'h100, 0, 32'h080, 0, 0, 32'h108, 1, 32'h104};
    vecs[4]  = '{32'h100, 0, 32'h000, 0, 32'h000, 0, 0, 32'h080, 0, 32'h004};
    vecs[5]  = '{32'h108, 1, 32'h100, 0, 32'h000, 0, 0, 32'h10c, 0, 32'h104};
    vecs[6]  = '{32'h10c, 1, 32'h100, 0, 32'h000, 0, 0, 32'h110, 0, 32'h104};
    vecs[7]  = '{32'h100, 1, 32'h100, 1, 32'h080, 0, 0, 32'h080, 1, 32'h080};
    vecs[8]  = '{32'h200, 1, 32'h200, 1, 32'h300, 0, 0, 32'h204, 1, 32'h300};
    vecs[9]  = '{32'h100, 0, 32'h000, 0, 32'h000, 0, 0, 32'h104, 0, 32'h004};
    vecs[10] = '{32'h200, 0, 32'h000, 0, 32'h000, 0, 1, 32'h300, 0, 32'h004};
    vecs[11] = '{32'h204, 1, 32'h200, 1, 32'h300, 0, 0, 32'h208, 0, 32'h300};
    vecs[12] = '{32'h200, 0, 32'h000, 0, 32'h000, 1, 1, 32'h300, 0, 32'h004};
    vecs[13] = '{32'h000, 1, 32'h204, 0, 32'h000, 0, 0, 32'h004, 0, 32'h208};
    vecs[14] = '{32'h200, 1, 32'h200, 0, 32'h000, 0, 1, 32'h300, 0, 32'h204};
    vecs[15] = '{32'h200, 0, 32'h000, 0, 32'h000, 0, 1, 32'h300, 0, 32'h004};
    vecs[16] = '{32'h000, 1, 32'h200, 1, 32'h400, 0, 0, 32'h004, 1, 32'h400};
    vecs[17] = '{32'h200, 0, 32'h000, 0, 32'h000, 0, 1, 32'h400, 0, 32'h004};

    // Reset held with a taken resolve pending: nothing may be allocated.
    rst_n = 1'b0;
    stall = 1'b0;
    if_pc = 32'h100;
    res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1; res_target = 32'h80;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check1 ("reset pred_taken", pred_taken, 1'b0);
    check32("reset pred_target", pred_target, 32'h104);
    check1 ("reset mispredict", mispredict, 1'b0);
    check32("reset stat_branches", stat_branches, 32'h0);
    check32("reset stat_mispredicts", stat_mispredicts, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_valid = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if_pc = vecs[i].pc; res_valid = vecs[i].rv; res_pc = vecs[i].rpc;
      res_taken = vecs[i].rt; res_target = vecs[i].rtg; stall = vecs[i].st;
      #2;
      check1 ($sformatf("v%0d pred_taken", i), pred_taken, vecs[i].e_pt);
      check32($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_ptg);
      check1 ($sformatf("v%0d mispredict", i), mispredict, vecs[i].e_mp);
      check32($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rd);
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0; stall = 1'b0;
    #1;
    check32("table stat_branches", stat_branches, STATS ? 32'd10 : 32'd0);
    check32("table stat_mispredicts", stat_mispredicts, STATS ? 32'd5 : 32'd0);

    // Asynchronous reset mid-cycle while a taken resolve is presented.
    if_pc = 32'h200;
    res_valid = 1'b1; res_pc = 32'h300; res_taken = 1'b1; res_target = 32'h500;
    #2;
    rst_n = 1'b0;
    #1;
    check1 ("midrst pred_taken", pred_taken, 1'b0);
    check32("midrst pred_target", pred_target, 32'h204);
    check1 ("midrst mispredict", mispredict, 1'b0);
    check32("midrst stat_branches", stat_branches, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_valid = 1'b0;
    if_pc = 32'h300;
    #2;
    check1 ("post-rst 0x300 pred_taken", pred_taken, 1'b0);
    check32("post-rst 0x300 pred_target", pred_target, 32'h304);
    if_pc = 32'h200;
    #1;
    check1 ("post-rst 0x200 pred_taken", pred_taken, 1'b0);
    check32("post-rst 0x200 pred_target", pred_target, 32'h204);
    check32("post-rst stat_mispredicts", stat_mispredicts, 32'h0);

    // Randomized traffic over a few heavily aliased indices.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 600; c++) begin
      pcs = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) |
            (32'($urandom_range(0, 1)) << 20);
      if_pc = pcs;
      res_valid = ($urandom_range(0, 9) < 6);
      res_pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      res_taken = $urandom_range(0, 1) == 1;
      res_target = 32'h1000 * 32'($urandom_range(1, 3));
      stall = ($urandom_range(0, 4) == 0);
      #2;
      m_lookup(if_pc, ept, eptg);
      emp = res_valid && ((res_taken != m_id_taken) || (res_taken && (res_target != m_id_target)));
      erd = res_taken ? res_target : res_pc + 32'd4;
      check1 ($sformatf("rnd%0d pred_taken", c), pred_taken, ept);
      check32($sformatf("rnd%0d pred_target", c), pred_target, eptg);
      check1 ($sformatf("rnd%0d mispredict", c), mispredict, emp);
      check32($sformatf("rnd%0d redirect_pc", c), redirect_pc, erd);
      check32($sformatf("rnd%0d stat_branches", c), stat_branches, STATS ? m_br : 32'd0);
      check32($sformatf("rnd%0d stat_mispredicts", c), stat_mispredicts, STATS ? m_mp : 32'd0);
      @(posedge clk);
      if (res_valid) begin
        m_train(res_pc, res_taken, res_target);
        m_br = m_br + 32'd1;
      end
      if (emp) begin
        m_id_taken  = 1'b0;
        m_id_target = '0;
        m_mp = m_mp + 32'd1;
      end else if (!stall) begin
        m_id_taken  = ept;
        m_id_target = eptg;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
